// File: rtl/imem_loader_if.sv
// Bus bundles around the instruction-memory loader: the incoming byte
// stream (valid/ready) and the instruction-memory write port.

// Byte stream from the debug/UART source into the loader.
interface byte_stream_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// Instruction-memory write port; the loader is its only master.
interface imem_wr_if;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  modport master (output mem_we, output mem_waddr, output mem_wdata);
  modport slave  (input mem_we, input mem_waddr, input mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Collects little-endian bytes into
// 32-bit words, writes them to consecutive word addresses from 0 and keeps
// the CPU stalled for the duration of the load.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; illegal lengths raise err next cycle
// RECV   | accepting bytes into the word buffer, idle timer running
// WRITE  | one-cycle memory write of the assembled word
// DONE   | one-cycle done pulse, then back to IDLE

module imem_loader #(
  parameter int MEM_DEPTH = 256,
  parameter int LEN_W     = 9,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   load_len,
  byte_stream_if.slave       s_if,
  imem_wr_if.master          m_if,
  output logic               cpu_stall,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [LEN_W-1:0]   words_loaded
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      buf_q, buf_d;
  logic [CW-1:0]    idle_q, idle_d;
  logic             err_q, err_d;

  logic hs;
  logic len_ok;
  logic timeout_hit;
  logic last_word;

  assign hs          = (state_q == S_RECV) && s_if.s_valid;
  assign len_ok      = (load_len != '0) && (load_len <= LEN_W'(MEM_DEPTH));
  // The TIMEOUT-th consecutive empty RECV cycle aborts the load.
  assign timeout_hit = (state_q == S_RECV) && !s_if.s_valid &&
                       (idle_q == CW'(TIMEOUT - 1));
  assign last_word   = ((word_cnt_q + LEN_W'(1)) == len_q);

  assign err          = err_q;
  assign words_loaded = words_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: length, counters, word buffer, err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      word_cnt_q <= '0;
      words_q    <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      idle_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      words_q    <= words_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && len_ok) state_d = S_RECV;
      S_RECV: begin
        if (hs && (byte_cnt_q == 2'd3)) state_d = S_WRITE;
        else if (timeout_hit)           state_d = S_IDLE;
      end
      S_WRITE: state_d = last_word ? S_DONE : S_RECV;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; registers hold unless a state acts on them.
  always_comb begin
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    words_d    = words_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    idle_d     = idle_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d      = load_len;
            word_cnt_d = '0;
            words_d    = '0;
            byte_cnt_d = '0;
            idle_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (hs) begin
          buf_d[byte_cnt_q*8 +: 8] = s_if.s_data;
          byte_cnt_d               = byte_cnt_q + 2'd1;
          idle_d                   = '0;
        end else if (timeout_hit) begin
          // Partial word is dropped; already-written words stay counted.
          err_d      = 1'b1;
          idle_d     = '0;
          byte_cnt_d = '0;
        end else begin
          idle_d = idle_q + CW'(1);
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + LEN_W'(1);
        words_d    = words_q + LEN_W'(1);
        byte_cnt_d = '0;
        idle_d     = '0;
      end
      default: ;
    endcase
  end

  // Moore outputs; write address/data are forced to 0 outside WRITE.
  always_comb begin
    s_if.s_ready   = 1'b0;
    m_if.mem_we    = 1'b0;
    m_if.mem_waddr = '0;
    m_if.mem_wdata = '0;
    busy           = 1'b0;
    cpu_stall      = 1'b0;
    done           = 1'b0;
    case (state_q)
      S_RECV: begin
        s_if.s_ready = 1'b1;
        busy         = 1'b1;
        cpu_stall    = 1'b1;
      end
      S_WRITE: begin
        m_if.mem_we    = 1'b1;
        m_if.mem_waddr = 32'({word_cnt_q, 2'b00});
        m_if.mem_wdata = buf_q;
        busy           = 1'b1;
        cpu_stall      = 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        cpu_stall = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: reset, two-word loads with and
// without byte gaps, timeout abort, illegal lengths, full-depth load with
// a stray start, and reset in the middle of a load.

module tb_imem_loader;
  localparam int MEM_DEPTH = 256;
  localparam int LEN_W     = 9;
  localparam int TIMEOUT   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] load_len = '0;
  logic             cpu_stall, busy, done, err;
  logic [LEN_W-1:0] words_loaded;

  byte_stream_if s_if ();
  imem_wr_if     m_if ();

  imem_loader #(.MEM_DEPTH(MEM_DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .load_len     (load_len),
    .s_if         (s_if),
    .m_if         (m_if),
    .cpu_stall    (cpu_stall),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte source: presents the head of byte_q, pops after a handshake.
  logic [7:0] byte_q[$];
  bit         feed_en  = 1'b0;
  bit         gap_mode = 1'b0;
  bit         hs_pend  = 1'b0;
  logic       rnd_valid = 1'b0;
  logic [7:0] rnd_data  = '0;

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    forever begin
      @(negedge clk);
      if (hs_pend && byte_q.size() > 0) byte_q.delete(0);
      if (!feed_en) begin
        s_if.s_valid = rnd_valid;
        s_if.s_data  = rnd_data;
      end else if (byte_q.size() > 0 && !(gap_mode && cyc[0])) begin
        s_if.s_valid = 1'b1;
        s_if.s_data  = byte_q[0];
      end else begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
      end
      hs_pend = feed_en && s_if.s_valid && s_if.s_ready;
    end
  end

  // Recorder of observed events, in spec cycle numbers (cycle after edge).
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  int          err_cyc[$];
  int          stall_first, stall_last;
  bit          stall_seen, rdy_seen, busy_seen;
  int          both_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_if.mem_we) begin
        wr_addr.push_back(m_if.mem_waddr);
        wr_data.push_back(m_if.mem_wdata);
        wr_cyc.push_back(cyc + 1);
      end
      if (done) done_cyc.push_back(cyc + 1);
      if (err)  err_cyc.push_back(cyc + 1);
      if (cpu_stall) begin
        if (!stall_seen) stall_first = cyc + 1;
        stall_seen = 1'b1;
        stall_last = cyc + 1;
      end
      if (s_if.s_ready) rdy_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (done && err) both_cnt++;
    end
  end

  task automatic clear_rec();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_cyc.delete(); err_cyc.delete();
    stall_seen = 1'b0; rdy_seen = 1'b0; busy_seen = 1'b0;
    stall_first = 0; stall_last = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) byte_q.push_back(w[b*8 +: 8]);
  endtask

  // Pulse start for one cycle; k is the edge at which it was sampled.
  task automatic do_start(input int len, output int k);
    @(posedge clk); #1;
    clear_rec();
    @(negedge clk);
    start    = 1'b1;
    load_len = len[LEN_W-1:0];
    @(negedge clk);
    k     = cyc;
    start = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done_cyc.size() > 0 || err_cyc.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] exp_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, 8'hC3, ~b, b ^ 8'h5A};
  endfunction

  task automatic test_reset();
    logic [31:0] r;
    logic [78:0] outs;
    feed_en = 1'b0;
    rst     = 1'b1;
    repeat (2) begin
      @(negedge clk);
      r = $urandom; rnd_valid = r[0]; rnd_data = r[15:8]; start = r[1];
      r = $urandom; load_len = r[LEN_W-1:0];
      outs = {s_if.s_ready, m_if.mem_we, m_if.mem_waddr, m_if.mem_wdata,
              cpu_stall, busy, done, err, words_loaded};
      n_cmp++;
      if (outs !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got %h expected 0", outs);
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; rnd_valid = 1'b1; rnd_data = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if ({s_if.s_ready, busy, cpu_stall} !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_after_reset: got rdy/busy/stall=%b expected 000",
                 {s_if.s_ready, busy, cpu_stall});
      end
    end
    rnd_valid = 1'b0;
    feed_en   = 1'b1;
  endtask

  task automatic test_two_word(input bit gap);
    int k;
    bit ok;
    byte_q.delete();
    gap_mode = gap;
    push_word(32'h0000_0013);
    push_word(32'h0010_0093);
    do_start(2, k);
    wait_end(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL two_word_end(gap=%0d): no done/err within bound", gap); end
    n_cmp++;
    if (wr_addr.size() != 2) begin n_bad++; $display("FAIL two_word_writes(gap=%0d): got %0d expected 2", gap, wr_addr.size()); end
    n_cmp++;
    if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h0000_0013) begin
      n_bad++; $display("FAIL two_word_w0(gap=%0d): got %h/%h expected 0/00000013", gap, wr_addr[0], wr_data[0]);
    end
    n_cmp++;
    if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0010_0093) begin
      n_bad++; $display("FAIL two_word_w1(gap=%0d): got %h/%h expected 4/00100093", gap, wr_addr[1], wr_data[1]);
    end
    if (!gap) begin
      n_cmp++;
      if (wr_cyc[0] != k + 5 || wr_cyc[1] != k + 10) begin
        n_bad++; $display("FAIL two_word_we_timing: got k+%0d,k+%0d expected k+5,k+10", wr_cyc[0] - k, wr_cyc[1] - k);
      end
      n_cmp++;
      if (done_cyc[0] != k + 11) begin
        n_bad++; $display("FAIL two_word_done_timing: got k+%0d expected k+11", done_cyc[0] - k);
      end
      n_cmp++;
      if (stall_first != k + 1 || stall_last != k + 11) begin
        n_bad++; $display("FAIL two_word_stall: got k+%0d..k+%0d expected k+1..k+11", stall_first - k, stall_last - k);
      end
    end else begin
      n_cmp++;
      if (done_cyc[0] <= k + 11) begin
        n_bad++; $display("FAIL gap_done_later: got k+%0d expected > k+11", done_cyc[0] - k);
      end
    end
    n_cmp++;
    if (done_cyc.size() != 1 || err_cyc.size() != 0) begin
      n_bad++; $display("FAIL two_word_pulses(gap=%0d): got done=%0d err=%0d expected 1/0", gap, done_cyc.size(), err_cyc.size());
    end
    n_cmp++;
    if (words_loaded !== 9'd2) begin n_bad++; $display("FAIL two_word_count(gap=%0d): got %0d expected 2", gap, words_loaded); end
    gap_mode = 1'b0;
  endtask

  task automatic test_timeout();
    int k;
    bit ok;
    byte_q.delete();
    push_word(32'h0000_0013);
    byte_q.push_back(8'h93);
    byte_q.push_back(8'h00);
    do_start(2, k);
    wait_end(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL timeout_end: no err within bound"); end
    n_cmp++;
    if (err_cyc.size() != 1 || err_cyc[0] != k + 24) begin
      n_bad++; $display("FAIL timeout_err: got %0d pulses at k+%0d expected 1 at k+24", err_cyc.size(), err_cyc[0] - k);
    end
    n_cmp++;
    if (wr_addr.size() != 1 || done_cyc.size() != 0) begin
      n_bad++; $display("FAIL timeout_writes: got we=%0d done=%0d expected 1/0", wr_addr.size(), done_cyc.size());
    end
    n_cmp++;
    if (words_loaded !== 9'd1) begin n_bad++; $display("FAIL timeout_count: got %0d expected 1", words_loaded); end
    n_cmp++;
    if ({cpu_stall, busy, s_if.s_ready} !== 3'b000) begin
      n_bad++; $display("FAIL timeout_idle: got stall/busy/rdy=%b expected 000", {cpu_stall, busy, s_if.s_ready});
    end
  endtask

  task automatic test_illegal(input int len, input int exp_wl);
    int k;
    byte_q.delete();
    do_start(len, k);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (err_cyc.size() != 1 || err_cyc[0] != k + 1) begin
      n_bad++; $display("FAIL illegal_err(len=%0d): got %0d pulses at k+%0d expected 1 at k+1", len, err_cyc.size(), err_cyc[0] - k);
    end
    n_cmp++;
    if ({rdy_seen, stall_seen, busy_seen} !== 3'b000 || wr_addr.size() != 0) begin
      n_bad++; $display("FAIL illegal_quiet(len=%0d): got rdy/stall/busy=%b we=%0d expected 000/0", len, {rdy_seen, stall_seen, busy_seen}, wr_addr.size());
    end
    n_cmp++;
    if (words_loaded !== exp_wl[LEN_W-1:0]) begin
      n_bad++; $display("FAIL illegal_count(len=%0d): got %0d expected %0d", len, words_loaded, exp_wl);
    end
  endtask

  task automatic test_full();
    int k;
    int bad;
    bit ok;
    byte_q.delete();
    for (int i = 0; i < MEM_DEPTH; i++) push_word(exp_word(i));
    do_start(MEM_DEPTH, k);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = (i == 50);
      if (i == 50) load_len = 9'd1;
      if (done_cyc.size() > 0 || err_cyc.size() > 0) begin ok = 1'b1; break; end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL full_end: no done/err within bound"); end
    n_cmp++;
    if (wr_addr.size() != MEM_DEPTH) begin n_bad++; $display("FAIL full_writes: got %0d expected %0d", wr_addr.size(), MEM_DEPTH); end
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== exp_word(i)) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL full_data: got %0d bad words expected 0", bad); end
    n_cmp++;
    if (wr_addr[MEM_DEPTH-1] !== 32'h3FC) begin n_bad++; $display("FAIL full_last_addr: got %h expected 000003fc", wr_addr[MEM_DEPTH-1]); end
    n_cmp++;
    if (done_cyc.size() != 1 || done_cyc[0] != k + 1281 || err_cyc.size() != 0) begin
      n_bad++; $display("FAIL full_done: got %0d at k+%0d err=%0d expected 1 at k+1281 err=0", done_cyc.size(), done_cyc[0] - k, err_cyc.size());
    end
    n_cmp++;
    if (words_loaded !== 9'd256) begin n_bad++; $display("FAIL full_count: got %0d expected 256", words_loaded); end
  endtask

  task automatic test_reset_midload();
    int k;
    bit ok;
    byte_q.delete();
    for (int i = 0; i < 8; i++) push_word(exp_word(i + 7));
    do_start(8, k);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_addr.size() >= 3) begin ok = 1'b1; break; end
    end
    rst = 1'b1;
    byte_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midrst_reach3: third write not seen within bound"); end
    n_cmp++;
    if (wr_addr.size() != 3 || done_cyc.size() != 0 || err_cyc.size() != 0) begin
      n_bad++; $display("FAIL midrst_quiet: got we=%0d done=%0d err=%0d expected 3/0/0", wr_addr.size(), done_cyc.size(), err_cyc.size());
    end
    n_cmp++;
    if ({cpu_stall, busy, s_if.s_ready} !== 3'b000 || words_loaded !== '0) begin
      n_bad++; $display("FAIL midrst_idle: got stall/busy/rdy=%b wl=%0d expected 000/0", {cpu_stall, busy, s_if.s_ready}, words_loaded);
    end
    push_word(32'hDEAD_BEEF);
    do_start(1, k);
    wait_end(100, ok);
    n_cmp++;
    if (!ok || wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEAD_BEEF || words_loaded !== 9'd1) begin
      n_bad++; $display("FAIL midrst_recover: got we=%0d addr=%h data=%h wl=%0d expected 1/0/deadbeef/1",
                        wr_addr.size(), wr_addr[0], wr_data[0], words_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_two_word(1'b0);
    test_two_word(1'b1);
    test_timeout();
    test_illegal(0, 1);
    test_illegal(257, 1);
    test_full();
    test_reset_midload();
    n_cmp++;
    if (both_cnt != 0) begin n_bad++; $display("FAIL done_err_overlap: got %0d cycles expected 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word to the instruction memory write port at consecutive word addresses from 0, and holds the CPU stalled until the load completes or aborts. It sits between the external debug/UART byte source and the instruction memory, and is the only writer of that memory.

## Interface
- MEM_DEPTH, 256, instruction memory depth in 32-bit words
- LEN_W, 9, width of length/count fields; must hold MEM_DEPTH
- TIMEOUT, 1024, idle cycles in RECV before the load aborts
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a load; sampled only in IDLE
- load_len  in  LEN_W  words to load, legal 1..MEM_DEPTH; sampled with start
- s_valid  in  1  byte source has data
- s_data  in  8  byte payload
- s_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable
- mem_waddr  out  32  byte address, word aligned
- mem_wdata  out  32  assembled instruction word
- cpu_stall  out  1  hold the CPU PC/fetch
- busy  out  1  load in progress
- done  out  1  one-cycle pulse, load completed
- err  out  1  one-cycle pulse, illegal length or timeout
- words_loaded  out  LEN_W  words written by the most recent load

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - s_ready=0, mem_we=0, busy=0, cpu_stall=0.
  - start with load_len==0 or >MEM_DEPTH: err=1 next cycle; stay IDLE; words_loaded unchanged.
  - Legal start: latch the length; clear word_cnt, byte_cnt, idle counter and words_loaded; go to RECV.
- RECV:
  - s_ready=1, busy=1, cpu_stall=1.
  - Handshake (s_valid&&s_ready): s_data goes into buffer lane byte_cnt (first byte to [7:0], fourth to [31:24]), byte_cnt++, idle counter cleared.
  - The 4th accepted byte moves the state to WRITE.
  - Each RECV cycle without a handshake increments the idle counter. On reaching TIMEOUT: err=1, partial word discarded, no write, go to IDLE. words_loaded keeps the full words already written.
- WRITE:
  - Exactly one cycle. mem_we=1, mem_waddr={word_cnt,2'b00} zero-extended to 32 bits, mem_wdata=buffer, s_ready=0.
  - word_cnt++ and words_loaded++.
  - If the incremented count equals the latched length, go to DONE; else go to RECV with byte_cnt=0.
- DONE: done=1 for one cycle, busy=1, cpu_stall=1; go to IDLE.
- start outside IDLE is ignored. load_len is not re-sampled mid-load.
- mem_waddr and mem_wdata are don't-care while mem_we=0, but are driven to 0 outside WRITE.
- Byte address arithmetic never wraps: the last legal write address is 4*(MEM_DEPTH-1).

## Timing
- Reset (rst high at an edge): state=IDLE; all outputs 0, including s_ready, mem_we, mem_waddr, mem_wdata, cpu_stall, busy, done, err and words_loaded.
- Reset mid-load: it takes effect at that edge. No further mem_we, no done, no err. Already-written words stay in memory.
- Legal start sampled at edge k: RECV from cycle k+1.
- With continuous s_valid, word i has mem_we high in cycle k+5+5i, i.e. 5 cycles per word.
- done is high in the cycle after the last WRITE. cpu_stall falls in the cycle after done.
- Byte stalls (s_valid low) extend RECV cycle-for-cycle with no data loss.
- The illegal-length err pulse is in cycle k+1, with busy=0 throughout.
- Timeout: err is high in the cycle after the idle counter reaches TIMEOUT, and the state is IDLE in that same cycle.
- done and err are never high in the same cycle.

## Test plan
- Reset: hold rst 2 cycles with random inputs. Every output is 0 and s_ready stays 0 until a legal start.
- Two-word load, continuous bytes 13 00 00 00 93 00 10 00, load_len=2, start at edge k:
  - mem_we at k+5 with addr 0x0, data 0x00000013.
  - mem_we at k+10 with addr 0x4, data 0x00100093.
  - done at k+11; words_loaded=2; cpu_stall high k+1..k+11.
- Same load with s_valid low on alternate cycles (gaps < TIMEOUT): identical writes and data, later cycles, no err.
- Timeout, with TIMEOUT=16:
  - Load 1 full word, then send 2 bytes and stop.
  - err after 16 idle cycles; exactly one mem_we ever seen; words_loaded=1; cpu_stall=0 afterwards.
- Illegal lengths: load_len=0, then load_len=257. Each gives an err pulse, no s_ready and no cpu_stall.
- Full load and robustness:
  - MEM_DEPTH words: last write at addr 0x3FC.
  - A start asserted mid-load has no effect.
  - A second run with rst asserted after 3 words: no done, idle behaviour resumes.
